mem_access_unit: RTL and testbench

Load/store controller for the pipeline's MEM stage, sitting directly upstream of the 256x32 data RAM. It accepts one byte/halfword/word load or store per request from the EX/MEM pipeline register and converts it into word-wide RAM accesses. Sub-word stores become read-modify-write sequences, and loads are sign- or zero-extended. The pipeline is stalled until the access completes.

---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-RAM bus between the MEM stage, the load/store unit and the RAM
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_enable;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_dout,
        output stall, rsp_valid, rsp_rdata, rsp_err, ram_enable, ram_rw, ram_addr, ram_din
    );
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_dout,
        input  stall, rsp_valid, rsp_rdata, rsp_err, ram_enable, ram_rw, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller turning byte/half/word accesses into word RAM reads, writes and read-modify-writes
module mem_access_unit #(
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        ram_enable_q, ram_enable_d;
    logic        ram_rw_q, ram_rw_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic [4:0]  sh;
    logic [31:0] lane, load_val, merged;
    logic        req_err;
    // lane extraction/extension for loads, lane merge for sub-word stores, and request legality
    always_comb begin
        sh       = {off_q, 3'b000};
        lane     = bus.ram_dout >> sh;
        load_val = size_q == 2'b00 ? {{24{signed_q & lane[7]}}, lane[7:0]}
                 : size_q == 2'b01 ? {{16{signed_q & lane[15]}}, lane[15:0]}
                 : bus.ram_dout;
        merged   = size_q == 2'b00 ? (bus.ram_dout & ~(32'h0000_00FF << sh)) | ({24'b0, wdata_q[7:0]} << sh)
                 : (bus.ram_dout & ~(32'h0000_FFFF << sh)) | ({16'b0, wdata_q} << sh);
        req_err  = (bus.req_size == 2'b11)
                 | (bus.req_size == 2'b01 & bus.req_addr[0])
                 | (bus.req_size == 2'b10 & bus.req_addr[1:0] != 2'b00)
                 | (bus.req_addr[31:10] != 22'b0);
    end
    // next state, latched request and registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                off_d      = bus.req_addr[1:0];
                size_d     = bus.req_size;
                signed_d   = bus.req_signed;
                write_d    = bus.req_write;
                wdata_d    = bus.req_wdata[15:0];
                ram_addr_d = {22'b0, bus.req_addr[9:2]};
                cnt_d      = LAT_M1;
                if (req_err) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (bus.req_write && bus.req_size == 2'b10) begin
                    state_d   = WR;
                    ram_din_d = bus.req_wdata;
                end else begin
                    state_d = RD;
                end
            end
            RD: if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end else if (write_q) begin
                state_d   = WR;
                ram_din_d = merged;
            end else begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_val;
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: state_d = IDLE;
        endcase
        ram_enable_d = state_d == RD || state_d == WR;
        ram_rw_d     = state_d != WR;
    end
    // state and output registers; reset drops the RAM enable at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            off_q        <= 2'b0;
            size_q       <= 2'b0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= 16'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'b0;
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b1;
            ram_addr_q   <= 32'b0;
            ram_din_q    <= 32'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            ram_enable_q <= ram_enable_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
        end
    end
    assign bus.stall      = (state_q == IDLE && bus.req_valid) || state_q == RD || state_q == WR;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.ram_enable = ram_enable_q;
    assign bus.ram_rw     = ram_rw_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench for mem_access_unit with word-RAM models at RD_LAT 1 and 3
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    mem_access_unit_if b1();
    mem_access_unit_if b3();
    mem_access_unit #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_access_unit #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    always #5 clk = ~clk;
    assign b1.ram_dout = mem1[b1.ram_addr[7:0]];
    assign b3.ram_dout = mem3[b3.ram_addr[7:0]];
    always @(posedge clk) begin
        if (b1.ram_enable && !b1.ram_rw) mem1[b1.ram_addr[7:0]] <= b1.ram_din;
        if (b3.ram_enable && !b3.ram_rw) mem3[b3.ram_addr[7:0]] <= b3.ram_din;
    end
    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] word4;
    } vec_t;
    vec_t v [24];
    int nv;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic add(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err, input int lat, input logic [31:0] word4);
        v[nv] = '{nm, wr, sz, sg, addr, wdata, rdata, err, lat, word4};
        nv++;
    endtask
    task automatic run_vec(input int i);
        int lat = 0;
        int en = 0;
        int stall_low = 0;
        logic got = 1'b0;
        logic [31:0] rd;
        logic er;
        logic st;
        @(negedge clk);
        b1.req_write  = v[i].wr;
        b1.req_size   = v[i].sz;
        b1.req_signed = v[i].sg;
        b1.req_addr   = v[i].addr;
        b1.req_wdata  = v[i].wdata;
        b1.req_valid  = 1'b1;
        #1;
        chk({v[i].name, " stall0"}, 32'(b1.stall), 32'd1);
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b1.rsp_valid) got = 1'b1;
            else begin
                en += int'(b1.ram_enable);
                if (!b1.stall) stall_low++;
            end
        end
        rd = b1.rsp_rdata;
        er = b1.rsp_err;
        st = b1.stall;
        b1.req_valid = 1'b0;
        chk({v[i].name, " latency"}, 32'(lat), 32'(v[i].lat));
        chk({v[i].name, " rdata"}, rd, v[i].rdata);
        chk({v[i].name, " err"}, 32'(er), 32'(v[i].err));
        chk({v[i].name, " ram_en_cycles"}, 32'(en), 32'(v[i].lat - 1));
        chk({v[i].name, " stall_busy"}, 32'(stall_low), 32'd0);
        chk({v[i].name, " stall_resp"}, 32'(st), 32'd0);
        @(posedge clk);
        #1;
        chk({v[i].name, " pulse_end"}, {31'b0, b1.rsp_valid | b1.ram_enable}, 32'd0);
        chk({v[i].name, " word4"}, mem1[4], v[i].word4);
    endtask
    initial begin
        int c3;
        int en3;
        int r1;
        int r2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] lo5;
        int bad;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'(i) * 32'h0101_0101;
            mem3[i] = 32'(i) * 32'h0101_0101;
        end
        mem1[4] = 32'h0;
        mem3[0] = 32'hA5A5_0001;
        mem3[1] = 32'h0000_0002;
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_size = 2'b10; b1.req_signed = 1'b0;
        b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_size = 2'b10; b3.req_signed = 1'b0;
        b3.req_addr = 32'h0; b3.req_wdata = 32'h0;
        #12;
        chk("reset rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(b1.rsp_err), 32'd0);
        chk("reset rsp_rdata", b1.rsp_rdata, 32'd0);
        chk("reset ram_enable", 32'(b1.ram_enable), 32'd0);
        chk("reset ram_rw", 32'(b1.ram_rw), 32'd1);
        chk("reset ram_addr", b1.ram_addr, 32'd0);
        chk("reset ram_din", b1.ram_din, 32'd0);
        chk("reset stall_hi", 32'(b1.stall), 32'd1);
        b1.req_valid = 1'b0;
        #1;
        chk("reset stall_lo", 32'(b1.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        add("st_word",    1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF);
        add("ld_word",    0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 32'hDEADBEEF);
        add("st_word2",   1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0, 2, 32'h11223344);
        add("st_byte",    1, 2'b00, 0, 32'h12, 32'h123456AA, 32'h0,        0, 3, 32'h11AA3344);
        add("st_half",    1, 2'b01, 0, 32'h10, 32'hCAFEBEEF, 32'h0,        0, 3, 32'h11AABEEF);
        add("st_byte3",   1, 2'b00, 0, 32'h13, 32'h00000077, 32'h0,        0, 3, 32'h77AABEEF);
        add("st_word3",   1, 2'b10, 0, 32'h10, 32'h8000F0FF, 32'h0,        0, 2, 32'h8000F0FF);
        add("ld_sb0",     0, 2'b00, 1, 32'h10, 32'h0,        32'hFFFFFFFF, 0, 2, 32'h8000F0FF);
        add("ld_ub1",     0, 2'b00, 0, 32'h11, 32'h0,        32'h000000F0, 0, 2, 32'h8000F0FF);
        add("ld_sh2",     0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF8000, 0, 2, 32'h8000F0FF);
        add("ld_uh2",     0, 2'b01, 0, 32'h12, 32'h0,        32'h00008000, 0, 2, 32'h8000F0FF);
        add("ld_sb1",     0, 2'b00, 1, 32'h11, 32'h0,        32'hFFFFFFF0, 0, 2, 32'h8000F0FF);
        add("ld_sb3",     0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 32'h8000F0FF);
        add("ld_ub2",     0, 2'b00, 0, 32'h12, 32'h0,        32'h00000000, 0, 2, 32'h8000F0FF);
        add("ld_sh0",     0, 2'b01, 1, 32'h10, 32'h0,        32'hFFFFF0FF, 0, 2, 32'h8000F0FF);
        add("ld_word_sg", 0, 2'b10, 1, 32'h10, 32'h0,        32'h8000F0FF, 0, 2, 32'h8000F0FF);
        add("err_wmis",   0, 2'b10, 0, 32'h11, 32'h0,        32'h0,        1, 1, 32'h8000F0FF);
        add("err_hmis",   1, 2'b01, 0, 32'h13, 32'h1234,     32'h0,        1, 1, 32'h8000F0FF);
        add("err_size",   0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 32'h8000F0FF);
        add("err_range",  0, 2'b00, 0, 32'h400, 32'h0,       32'h0,        1, 1, 32'h8000F0FF);
        add("err_rng_st", 1, 2'b00, 0, 32'h410, 32'h55,      32'h0,        1, 1, 32'h8000F0FF);
        add("err_hi",     1, 2'b10, 0, 32'h80000010, 32'h0,  32'h0,        1, 1, 32'h8000F0FF);
        for (int i = 0; i < nv; i++) run_vec(i);
        chk("err_rng_st word4_alias", mem1[4], 32'h8000F0FF);
        chk("err_range word0", mem1[0], 32'h0);
        @(negedge clk);
        b3.req_write = 1'b0; b3.req_size = 2'b10; b3.req_signed = 1'b0;
        b3.req_addr = 32'h0; b3.req_valid = 1'b1;
        c3 = 0; en3 = 0; r1 = -1; r2 = -1; d1 = 32'h0; d2 = 32'h0; lo5 = 32'h1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            c3++;
            en3 += int'(b3.ram_enable);
            if (c3 == 5) lo5 = {31'b0, b3.ram_enable};
            if (b3.rsp_valid && r1 < 0) begin
                r1 = c3; d1 = b3.rsp_rdata; b3.req_addr = 32'h4;
            end else if (b3.rsp_valid && r2 < 0) begin
                r2 = c3; d2 = b3.rsp_rdata; b3.req_valid = 1'b0;
            end
        end
        b3.req_valid = 1'b0;
        chk("lat3 rsp1_cycle", 32'(r1), 32'd4);
        chk("lat3 rsp1_data", d1, 32'hA5A5_0001);
        chk("lat3 rsp2_cycle", 32'(r2), 32'd9);
        chk("lat3 rsp2_data", d2, 32'h0000_0002);
        chk("lat3 en_cycles", 32'(en3), 32'd6);
        chk("lat3 idle_gap", lo5, 32'd0);
        @(negedge clk);
        b1.req_write = 1'b1; b1.req_size = 2'b00; b1.req_signed = 1'b0;
        b1.req_addr = 32'h10; b1.req_wdata = 32'h55; b1.req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid rd_enable", {31'b0, b1.ram_enable & b1.ram_rw}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid ram_enable", 32'(b1.ram_enable), 32'd0);
        chk("rst_mid ram_rw", 32'(b1.ram_rw), 32'd1);
        chk("rst_mid ram_addr", b1.ram_addr, 32'd0);
        chk("rst_mid ram_din", b1.ram_din, 32'd0);
        chk("rst_mid rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("rst_mid stall", 32'(b1.stall), 32'(b1.req_valid));
        b1.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (b1.rsp_valid || b1.ram_enable) bad++;
        end
        chk("rst_mid no_activity", 32'(bad), 32'd0);
        chk("rst_mid word4", mem1[4], 32'h8000F0FF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
